// File: rtl/stack_cmd_sequencer.sv
// stack_cmd_sequencer
//   Front end for a WIDTH-bit, DEPTH-entry stack. It accepts one request at a
//   time, tracks how full the stack is, and rejects overflow, underflow and
//   out-of-range GET requests without touching the stack. Legal requests are
//   sent to the stack as a one-cycle command. POP/GET data comes back on a
//   valid/ready response channel.
//
// Ports
//   CLK, RESET     clock; synchronous active-high reset
//   CLR            clear request, honoured only while idle
//   REQ_*          request channel (VALID/READY, OP, INDEX, DATA)
//   RSP_*          response channel (VALID/READY, DATA, ERR)
//   COUNT          current stack occupancy, 0..DEPTH
//   ST_RESET       stack reset, pulsed for one cycle after reset/clear
//   ST_COMMAND     stack command (NOP=00 PUSH=01 POP=10 GET=11)
//   ST_INDEX       stack GET index
//   ST_DATA        bidirectional stack data bus
module stack_cmd_sequencer #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IW    = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [IW-1:0]    REQ_INDEX,
    input  logic [WIDTH-1:0] REQ_DATA,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic             RSP_ERR,
    output logic [IW-1:0]    COUNT,
    output logic             ST_RESET,
    output logic [1:0]       ST_COMMAND,
    output logic [IW-1:0]    ST_INDEX,
    inout  wire  [WIDTH-1:0] ST_DATA
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_GET  = 2'b11;

    localparam logic [IW-1:0] DEPTH_C = DEPTH[IW-1:0];

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             st_reset_q, st_reset_d;
    logic             req_err;

    // Legality check on the incoming request, made against the current occupancy.
    always_comb begin
        req_err = 1'b0;
        case (REQ_OP)
            OP_PUSH: req_err = (count_q == DEPTH_C);
            OP_POP:  req_err = (count_q == '0);
            OP_GET:  req_err = (count_q == '0) || (REQ_INDEX >= count_q);
            default: req_err = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        idx_d      = idx_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        st_reset_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CLR) begin
                    count_d    = '0;
                    st_reset_d = 1'b1;
                end else if (REQ_VALID) begin
                    op_d       = REQ_OP;
                    // The stack expects index 0 for PUSH/POP.
                    idx_d      = (REQ_OP == OP_GET) ? REQ_INDEX : '0;
                    data_d     = REQ_DATA;
                    rsp_data_d = '0;
                    rsp_err_d  = req_err;
                    // Rejected requests and NOPs skip the stack entirely.
                    state_d    = (req_err || REQ_OP == OP_NOP) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (op_q)
                    OP_PUSH: count_d = count_q + 1'b1;
                    OP_POP: begin
                        count_d    = count_q - 1'b1;
                        rsp_data_d = ST_DATA;
                    end
                    OP_GET:  rsp_data_d = ST_DATA;
                    default: ;
                endcase
                rsp_err_d = 1'b0;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            op_q       <= OP_NOP;
            idx_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            st_reset_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            st_reset_q <= st_reset_d;
        end
    end

    assign REQ_READY  = (state_q == S_IDLE);
    assign RSP_VALID  = (state_q == S_RESP);
    assign RSP_DATA   = rsp_data_q;
    assign RSP_ERR    = rsp_err_q;
    assign COUNT      = count_q;
    assign ST_RESET   = st_reset_q;
    assign ST_COMMAND = (state_q == S_ISSUE) ? op_q : OP_NOP;
    assign ST_INDEX   = (state_q == S_ISSUE) ? idx_q : '0;

    // The sequencer drives the bus only while it issues a PUSH.
    assign ST_DATA = (state_q == S_ISSUE && op_q == OP_PUSH) ? data_q : 'z;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// tb_stack_cmd_sequencer
//   Directed bench for stack_cmd_sequencer. A small behavioural stack sits on
//   the ST_* side and drives read data during POP/GET.
module tb_stack_cmd_sequencer;

    logic       CLK = 1'b0;
    logic       RESET, CLR, REQ_VALID, REQ_READY, RSP_VALID, RSP_READY, RSP_ERR, ST_RESET;
    logic [1:0] REQ_OP, ST_COMMAND;
    logic [2:0] REQ_INDEX, COUNT, ST_INDEX;
    logic [3:0] REQ_DATA, RSP_DATA;
    wire  [3:0] ST_DATA;

    int n_checks = 0;
    int n_pass   = 0;

    stack_cmd_sequencer #(.DEPTH(5), .WIDTH(4), .IW(3)) dut (
        .CLK(CLK), .RESET(RESET), .CLR(CLR),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_INDEX(REQ_INDEX), .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_ERR(RSP_ERR), .COUNT(COUNT), .ST_RESET(ST_RESET),
        .ST_COMMAND(ST_COMMAND), .ST_INDEX(ST_INDEX), .ST_DATA(ST_DATA)
    );

    always #5 CLK = ~CLK;

    // Behavioural stack: top of stack is mem[sp-1]; GET index 0 is the top.
    logic [3:0] mem [0:7];
    int         sp = 0;
    logic       drv_en;
    logic [3:0] drv_val;

    always @(posedge CLK) begin
        if (ST_RESET === 1'b1) begin
            sp <= 0;
        end else if (ST_COMMAND === 2'b01) begin
            if (sp < 8) mem[sp] <= ST_DATA;
            sp <= sp + 1;
        end else if (ST_COMMAND === 2'b10) begin
            if (sp > 0) sp <= sp - 1;
        end
    end

    always_comb begin
        drv_en  = 1'b0;
        drv_val = '0;
        if ((ST_COMMAND == 2'b10 || ST_COMMAND == 2'b11) && sp > int'(ST_INDEX) && sp <= 8) begin
            drv_en  = 1'b1;
            drv_val = mem[sp - 1 - int'(ST_INDEX)];
        end
    end

    assign ST_DATA = drv_en ? drv_val : 'z;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One request from IDLE through to the response being taken.
    task automatic req(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] data,
                       input logic exp_err, input logic [3:0] exp_data, input logic [2:0] exp_count);
        logic legal;
        legal = !exp_err && (op != 2'b00);
        chk("req_ready_idle", {7'd0, REQ_READY}, 8'd1);
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_INDEX = idx;
        REQ_DATA  = data;
        tick();
        REQ_VALID = 1'b0;
        if (legal) begin
            chk("issue_cmd", {6'd0, ST_COMMAND}, {6'd0, op});
            chk("issue_index", {5'd0, ST_INDEX}, (op == 2'b11) ? {5'd0, idx} : 8'd0);
            chk("issue_ready", {7'd0, REQ_READY}, 8'd0);
            chk("issue_rsp_valid", {7'd0, RSP_VALID}, 8'd0);
            if (op == 2'b01) chk("push_bus", {4'd0, ST_DATA}, {4'd0, data});
            tick();
        end
        chk("resp_cmd_nop", {6'd0, ST_COMMAND}, 8'd0);
        chk("rsp_valid", {7'd0, RSP_VALID}, 8'd1);
        chk("rsp_err", {7'd0, RSP_ERR}, {7'd0, exp_err});
        chk("rsp_data", {4'd0, RSP_DATA}, {4'd0, exp_data});
        tick();
        chk("rsp_done", {7'd0, RSP_VALID}, 8'd0);
        chk("count", {5'd0, COUNT}, {5'd0, exp_count});
    endtask

    initial begin
        RESET     = 1'b1;
        CLR       = 1'b0;
        REQ_VALID = 1'b0;
        REQ_OP    = 2'b00;
        REQ_INDEX = '0;
        REQ_DATA  = '0;
        RSP_READY = 1'b1;

        // Reset held for two edges.
        tick();
        tick();
        chk("rst_st_reset", {7'd0, ST_RESET}, 8'd1);
        chk("rst_count", {5'd0, COUNT}, 8'd0);
        chk("rst_ready", {7'd0, REQ_READY}, 8'd1);
        chk("rst_rsp_valid", {7'd0, RSP_VALID}, 8'd0);
        chk("rst_cmd", {6'd0, ST_COMMAND}, 8'd0);
        chk("rst_index", {5'd0, ST_INDEX}, 8'd0);
        chk("rst_rsp_data", {4'd0, RSP_DATA}, 8'd0);
        RESET = 1'b0;
        tick();
        chk("rst_pulse_end", {7'd0, ST_RESET}, 8'd0);

        // Fill the stack, then overflow.
        for (int i = 1; i <= 5; i++) req(2'b01, 3'd0, 4'(i), 1'b0, 4'd0, 3'(i));
        req(2'b01, 3'd0, 4'd6, 1'b1, 4'd0, 3'd5);

        // GET every valid index, then one past the top.
        for (int i = 0; i < 5; i++) req(2'b11, 3'(i), 4'd0, 1'b0, 4'(5 - i), 3'd5);
        req(2'b11, 3'd5, 4'd0, 1'b1, 4'd0, 3'd5);

        // NOP takes the short path with no error.
        req(2'b00, 3'd0, 4'd0, 1'b0, 4'd0, 3'd5);

        // Drain, then underflow.
        for (int i = 0; i < 5; i++) req(2'b10, 3'd0, 4'd0, 1'b0, 4'(5 - i), 3'(4 - i));
        req(2'b10, 3'd0, 4'd0, 1'b1, 4'd0, 3'd0);
        req(2'b11, 3'd0, 4'd0, 1'b1, 4'd0, 3'd0);

        // Back-pressure on a POP response; CLR and new requests must be ignored.
        req(2'b01, 3'd0, 4'd7, 1'b0, 4'd0, 3'd1);
        req(2'b01, 3'd0, 4'd8, 1'b0, 4'd0, 3'd2);
        RSP_READY = 1'b0;
        REQ_VALID = 1'b1;
        REQ_OP    = 2'b10;
        tick();
        REQ_VALID = 1'b0;
        chk("bp_issue_cmd", {6'd0, ST_COMMAND}, 8'h02);
        tick();
        REQ_VALID = 1'b1;
        REQ_OP    = 2'b01;
        REQ_DATA  = 4'd9;
        CLR       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {7'd0, RSP_VALID}, 8'd1);
            chk("bp_data", {4'd0, RSP_DATA}, 8'd8);
            chk("bp_ready", {7'd0, REQ_READY}, 8'd0);
            chk("bp_cmd", {6'd0, ST_COMMAND}, 8'd0);
            chk("bp_count", {5'd0, COUNT}, 8'd1);
            chk("bp_no_clr", {7'd0, ST_RESET}, 8'd0);
            tick();
        end
        REQ_VALID = 1'b0;
        CLR       = 1'b0;
        RSP_READY = 1'b1;
        tick();
        chk("bp_release_valid", {7'd0, RSP_VALID}, 8'd0);
        chk("bp_release_ready", {7'd0, REQ_READY}, 8'd1);
        chk("bp_release_count", {5'd0, COUNT}, 8'd1);
        req(2'b11, 3'd0, 4'd0, 1'b0, 4'd7, 3'd1);

        // CLR in IDLE with three entries.
        req(2'b01, 3'd0, 4'd10, 1'b0, 4'd0, 3'd2);
        req(2'b01, 3'd0, 4'd11, 1'b0, 4'd0, 3'd3);
        CLR       = 1'b1;
        REQ_VALID = 1'b1;
        REQ_OP    = 2'b10;
        tick();
        CLR       = 1'b0;
        REQ_VALID = 1'b0;
        chk("clr_pulse", {7'd0, ST_RESET}, 8'd1);
        chk("clr_count", {5'd0, COUNT}, 8'd0);
        chk("clr_stay_idle", {7'd0, REQ_READY}, 8'd1);
        chk("clr_no_cmd", {6'd0, ST_COMMAND}, 8'd0);
        tick();
        chk("clr_pulse_end", {7'd0, ST_RESET}, 8'd0);
        req(2'b10, 3'd0, 4'd0, 1'b1, 4'd0, 3'd0);

        // RESET while a PUSH is being issued drops the request.
        REQ_VALID = 1'b1;
        REQ_OP    = 2'b01;
        REQ_DATA  = 4'd9;
        tick();
        REQ_VALID = 1'b0;
        chk("rstissue_cmd", {6'd0, ST_COMMAND}, 8'h01);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rstissue_count", {5'd0, COUNT}, 8'd0);
        chk("rstissue_valid", {7'd0, RSP_VALID}, 8'd0);
        chk("rstissue_cmd_nop", {6'd0, ST_COMMAND}, 8'd0);
        chk("rstissue_pulse", {7'd0, ST_RESET}, 8'd1);
        chk("rstissue_ready", {7'd0, REQ_READY}, 8'd1);
        tick();
        chk("rstissue_no_rsp", {7'd0, RSP_VALID}, 8'd0);
        chk("rstissue_pulse_end", {7'd0, ST_RESET}, 8'd0);
        req(2'b01, 3'd0, 4'd3, 1'b0, 4'd0, 3'd1);
        req(2'b10, 3'd0, 4'd0, 1'b0, 4'd3, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_cmd_sequencer.md
Name: stack_cmd_sequencer

Overview:
- Upstream front end for the 4-bit, 5-entry stack (COMMAND NOP=00, PUSH=01, POP=10, GET=11; INDEX 3-bit; bidirectional 4-bit data bus).
- Accepts one request at a time over a valid/ready handshake and tracks stack occupancy.
- Rejects overflow, underflow and out-of-range GET without touching the stack.
- Issues legal commands to the stack for exactly one cycle, owns the tri-state data bus, and returns POP/GET data over a valid/ready response channel.

Parameters:
- DEPTH, 5, stack capacity in entries; must match the stack instance.
- WIDTH, 4, data width.
- IW, 3, INDEX width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- CLR  in  1  synchronous clear request; honoured only in IDLE.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request ready.
- REQ_OP  in  2  request opcode, same encoding as the stack COMMAND.
- REQ_INDEX  in  IW  GET index, 0 = top of stack.
- REQ_DATA  in  WIDTH  PUSH data.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response ready.
- RSP_DATA  out  WIDTH  POP/GET result; 0 for all other responses.
- RSP_ERR  out  1  request rejected.
- COUNT  out  IW  current occupancy, 0..DEPTH.
- ST_RESET  out  1  drives the stack RESET.
- ST_COMMAND  out  2  drives the stack COMMAND.
- ST_INDEX  out  IW  drives the stack INDEX.
- ST_DATA  inout  WIDTH  stack data bus.

Behaviour:
- Reset (RESET high at an edge):
  - State goes to IDLE; COUNT=0; RSP_VALID=0; RSP_DATA=0; RSP_ERR=0.
  - ST_COMMAND=NOP; ST_INDEX=0; ST_DATA=Z.
  - ST_RESET=1 in the cycle after that edge, else 0.
  - Reset overrides any state; an in-flight request is dropped with no response.
- Bus ownership: ST_DATA is driven with the latched data only in ISSUE with op=PUSH; it is Z in every other state.
- ST_COMMAND is NOP in every state except ISSUE.
- State IDLE:
  - REQ_READY=1.
  - CLR=1 at an edge (takes priority over REQ_VALID, request not accepted): COUNT<=0, ST_RESET=1 for the following cycle, stay IDLE.
  - REQ_VALID=1 at an edge: latch op/index/data and check legality.
  - Error conditions: PUSH with COUNT==DEPTH; POP with COUNT==0; GET with COUNT==0 or REQ_INDEX>=COUNT.
  - Error or op=NOP: go to RESP with RSP_ERR=(error), RSP_DATA=0; no stack command issued.
  - Otherwise go to ISSUE.
- State ISSUE (exactly one cycle):
  - REQ_READY=0; ST_COMMAND=latched op; ST_INDEX=latched index (0 for PUSH/POP).
  - POP/GET: ST_DATA sampled at the closing edge into RSP_DATA.
  - PUSH: COUNT+1 at the closing edge. POP: COUNT-1 at the closing edge.
  - Go to RESP with RSP_ERR=0.
- State RESP:
  - RSP_VALID=1; REQ_READY=0; RSP_DATA and RSP_ERR held stable.
  - RSP_READY=1 at an edge: RSP_VALID<=0, go to IDLE.
  - Back-pressure has no bound; no command is issued while waiting.
- Latency:
  - Legal PUSH/POP/GET: RSP_VALID rises 2 cycles after the accepting edge.
  - Error/NOP: RSP_VALID rises 1 cycle after the accepting edge.
  - Minimum throughput: one request per 3 cycles (legal) or 2 cycles (error/NOP).
- COUNT never leaves 0..DEPTH. Wrap-around in the stack is never exercised because illegal requests are filtered.
- CLR/RESET while RSP_VALID=1: RESET aborts the response; CLR is ignored outside IDLE.

Test Plan:
- RESET=1 for 2 cycles, then 0 -> REQ_READY=1, COUNT=0, ST_COMMAND=00, ST_DATA=Z, ST_RESET=1 for one cycle after each reset edge.
- PUSH 1,2,3,4,5 with RSP_READY=1 -> each response has ERR=0; COUNT ends at 5; a sixth PUSH of 6 -> ERR=1, COUNT stays 5, ST_COMMAND stays 00.
- With 1..5 pushed, GET index 0..4 -> RSP_DATA 5,4,3,2,1; GET index 5 -> ERR=1, no stack command.
- Five POPs -> RSP_DATA 5,4,3,2,1 and COUNT 4..0; a sixth POP -> ERR=1, RSP_DATA=0.
- Hold RSP_READY=0 for 4 cycles after a POP -> RSP_VALID and RSP_DATA stable, REQ_READY=0, ST_COMMAND=00 throughout; release -> IDLE next cycle.
- With COUNT=3, assert CLR in IDLE -> ST_RESET pulse, COUNT=0. Assert RESET during ISSUE of a PUSH -> no response, COUNT=0, ST_DATA=Z next cycle.
